uart_mem_dump: RTL and testbench

Memory-to-UART dump engine: on a start pulse, reads a contiguous byte range from a synchronous-read byte memory (same 512 x 8 geometry and 1-cycle read latency as the UART RX FIFO) and transmits each byte as an 8N1 UART frame on the TX pin. It sits beside the receive/reload path in `top`. It drives the FIFO/memory read address while the CPU is held in reset, or reads a debug snapshot buffer, and owns `_20a`. It is the transmit counterpart of the RX-FIFO image loader.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx_serializer.sv | 80 ++++++++
 rtl/uart_mem_dump.sv | 109 ++++++++++
 tb/tb_uart_mem_dump.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: dump engine state encoding, 8N1 frame constants
// and a helper that assembles a frame from one data byte.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      LOAD,
      SEND,
      FINISH
   } dump_state_t;

   localparam int   UART_FRAME_BITS = 10;
   localparam logic UART_IDLE_LEVEL = 1'b1;

   // Start bit in bit 0 so the frame can be shifted out LSB first.
   function automatic logic [UART_FRAME_BITS-1:0] uartFrame(input logic [7:0] data);
      return {UART_IDLE_LEVEL, data, 1'b0};
   endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter: a one-cycle tx_go loads a byte and the frame is
// shifted out LSB first, each bit held for CLKS_PER_BIT clock cycles.
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 104
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tx_go,
   input  logic [7:0] tx_data,
   output logic       tx,
   output logic       tx_busy,
   output logic       tx_done
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [3:0]    LAST_BIT  = 4'(UART_FRAME_BITS - 1);

   logic [CW-1:0]              baudCnt_q, baudCnt_d;
   logic [3:0]                 bitIdx_q, bitIdx_d;
   logic [UART_FRAME_BITS-1:0] shiftReg_q, shiftReg_d;
   logic                       tx_q, tx_d;
   logic                       busy_q, busy_d;
   logic                       bitEnd;

   always_ff @(posedge clk) begin
      if (reset) begin
         baudCnt_q  <= '0;
         bitIdx_q   <= '0;
         shiftReg_q <= '0;
         tx_q       <= UART_IDLE_LEVEL;
         busy_q     <= 1'b0;
      end else begin
         baudCnt_q  <= baudCnt_d;
         bitIdx_q   <= bitIdx_d;
         shiftReg_q <= shiftReg_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
      end
   end

   // The line is driven from a register, so the start bit appears the cycle after tx_go.
   always_comb begin
      baudCnt_d  = baudCnt_q;
      bitIdx_d   = bitIdx_q;
      shiftReg_d = shiftReg_q;
      tx_d       = tx_q;
      busy_d     = busy_q;
      bitEnd     = busy_q && (baudCnt_q == BAUD_LAST);
      tx_done    = bitEnd && (bitIdx_q == LAST_BIT);

      if (!busy_q) begin
         if (tx_go) begin
            shiftReg_d = uartFrame(tx_data);
            tx_d       = 1'b0;
            baudCnt_d  = '0;
            bitIdx_d   = '0;
            busy_d     = 1'b1;
         end
      end else if (bitEnd) begin
         baudCnt_d = '0;
         if (bitIdx_q == LAST_BIT) begin
            busy_d = 1'b0;
            tx_d   = UART_IDLE_LEVEL;
         end else begin
            bitIdx_d   = bitIdx_q + 4'd1;
            shiftReg_d = {UART_IDLE_LEVEL, shiftReg_q[UART_FRAME_BITS-1:1]};
            tx_d       = shiftReg_q[1];
         end
      end else begin
         baudCnt_d = baudCnt_q + CW'(1);
      end
   end

   assign tx      = tx_q;
   assign tx_busy = busy_q;

endmodule

// File: rtl/uart_mem_dump.sv
// Memory-to-UART dump engine: streams a contiguous (wrapping) byte range
// from a 1-cycle-latency synchronous memory out as 8N1 frames.
module uart_mem_dump
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 104,
   parameter int ADDR_W       = 9
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   length,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] mem_ra,
   input  logic [7:0]        mem_rd,
   output logic              tx
);

   dump_state_t       state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W:0]   remaining_q, remaining_d;
   logic              txGo;
   logic              txBusy;
   logic              txDone;

   uart_tx_serializer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_serializer (
      .clk    (clk),
      .reset  (reset),
      .tx_go  (txGo),
      .tx_data(mem_rd),
      .tx     (tx),
      .tx_busy(txBusy),
      .tx_done(txDone)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         remaining_q <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         remaining_q <= remaining_d;
      end
   end

   // addr_q doubles as the memory read address; it only moves between frames,
   // so the memory output stays stable while the serializer owns the byte.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      remaining_d = remaining_q;
      txGo        = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (length != '0) begin
                  addr_d      = base_addr;
                  remaining_d = length;
                  state_d     = READ;
               end else begin
                  state_d = FINISH;
               end
            end
         end
         READ: begin
            busy = 1'b1;
            if (!txBusy) begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            busy        = 1'b1;
            txGo        = 1'b1;
            remaining_d = remaining_q - (ADDR_W+1)'(1);
            state_d     = SEND;
         end
         SEND: begin
            busy = 1'b1;
            if (txDone) begin
               if (remaining_q != '0) begin
                  addr_d  = addr_q + ADDR_W'(1);
                  state_d = READ;
               end else begin
                  state_d = FINISH;
               end
            end
         end
         FINISH: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign mem_ra = addr_q;

endmodule

// File: tb/tb_uart_mem_dump.sv
// Scoreboard bench for uart_mem_dump: stimulus queues expected frames and a
// UART decoder on tx pops and compares them as frames complete.
module tb_uart_mem_dump;

   localparam int CPB    = 4;
   localparam int ADDR_W = 9;
   localparam int DEPTH  = 1 << ADDR_W;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [7:0]        data;
   } expFrame_t;

   logic              clk;
   logic              reset;
   logic              start;
   logic [ADDR_W-1:0] baseAddr;
   logic [ADDR_W:0]   lenIn;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] mem_ra;
   logic [7:0]        mem_rd;
   logic              tx;

   logic [7:0] mem [DEPTH];
   expFrame_t  expQ[$];
   int         frameStarts[$];
   int         cyc;
   int         checks;
   int         failures;
   int         frameCount;
   int         doneCount;

   uart_mem_dump #(
      .CLKS_PER_BIT(CPB),
      .ADDR_W      (ADDR_W)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .base_addr(baseAddr),
      .length   (lenIn),
      .busy     (busy),
      .done     (done),
      .mem_ra   (mem_ra),
      .mem_rd   (mem_rd),
      .tx       (tx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous-read memory with one cycle of latency.
   always @(posedge clk) begin
      mem_rd <= mem[mem_ra];
   end

   always @(posedge clk) begin
      cyc++;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // Frame decoder: samples mid-bit, aborts on reset, checks against the queue.
   int                fc;
   bit                active;
   logic [9:0]        frameBits;
   logic [ADDR_W-1:0] frameAddr;
   always @(negedge clk) begin
      if (reset) begin
         active = 1'b0;
      end else if (!active) begin
         if (tx === 1'b0) begin
            active    = 1'b1;
            fc        = 0;
            frameAddr = mem_ra;
            frameStarts.push_back(cyc);
            frameCount++;
         end
      end else begin
         fc++;
         if (fc % CPB == CPB / 2) begin
            frameBits[fc / CPB] = tx;
         end
         if (fc == 9 * CPB + CPB / 2) begin
            active = 1'b0;
            checkOutput("frame_framing", {30'd0, frameBits[9], frameBits[0]}, 32'd2);
            if (expQ.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL unexpected_frame actual=0x%0h expected=none", frameBits[8:1]);
            end else begin
               expFrame_t e;
               e = expQ.pop_front();
               checkOutput("frame_data", {24'd0, frameBits[8:1]}, {24'd0, e.data});
               checkOutput("frame_addr", {23'd0, frameAddr}, {23'd0, e.addr});
            end
         end
      end
   end

   always @(negedge clk) begin
      if (done === 1'b1) doneCount++;
   end

   // Drives a start pulse from a negedge; returns at the negedge of cycle N+1.
   task automatic applyStimulus(input int base, input int len, input bit pushExp, output int n);
      baseAddr = ADDR_W'(base);
      lenIn    = (ADDR_W+1)'(len);
      start    = 1'b1;
      n        = cyc;
      if (pushExp) begin
         for (int i = 0; i < len; i++) begin
            expFrame_t e;
            e.addr = ADDR_W'((base + i) % DEPTH);
            e.data = mem[(base + i) % DEPTH];
            expQ.push_back(e);
         end
      end
      @(negedge clk);
      start    = 1'b0;
      baseAddr = ADDR_W'(311);
      lenIn    = (ADDR_W+1)'(77);
   endtask

   task automatic waitDone(input string name, input int budget, output int doneCyc);
      doneCyc = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            doneCyc = cyc;
            return;
         end
      end
      checks++;
      failures++;
      $display("[TB] FAIL %s_timeout actual=no_done expected=done_within_%0d", name, budget);
   endtask

   initial begin
      int n;
      int dc;
      int idx;
      int fcBefore;
      int dcBefore;
      int bad;

      cyc = 0;
      checks = 0;
      failures = 0;
      frameCount = 0;
      doneCount = 0;
      active = 1'b0;
      reset = 1'b1;
      start = 1'b0;
      baseAddr = '0;
      lenIn = '0;
      for (int i = 0; i < DEPTH; i++) mem[i] = 8'((i * 37 + 11) & 8'hFF);
      mem[5]   = 8'hA5;
      mem[510] = 8'h11;
      mem[511] = 8'h22;
      mem[0]   = 8'h33;
      mem[1]   = 8'h44;

      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      $display("[TB] reset values");
      checkOutput("reset_tx", {31'd0, tx}, 32'd1);
      checkOutput("reset_busy", {31'd0, busy}, 32'd0);
      checkOutput("reset_done", {31'd0, done}, 32'd0);
      checkOutput("reset_mem_ra", {23'd0, mem_ra}, 32'd0);

      $display("[TB] single byte");
      idx = frameStarts.size();
      applyStimulus(5, 1, 1'b1, n);
      checkOutput("single_busy_n1", {31'd0, busy}, 32'd1);
      waitDone("single", 200, dc);
      checkOutput("single_done_cycle", dc, n + 43);
      checkOutput("single_busy_at_done", {31'd0, busy}, 32'd0);
      checkOutput("single_tx_fall_cycle", (frameStarts.size() > idx) ? frameStarts[idx] : -1, n + 3);
      repeat (3) @(negedge clk);

      $display("[TB] address wrap");
      idx = frameStarts.size();
      applyStimulus(510, 4, 1'b1, n);
      waitDone("wrap", 400, dc);
      checkOutput("wrap_done_cycle", dc, n + 3 + 3 * 42 + 40);
      checkOutput("wrap_frame_count", frameStarts.size() - idx, 4);
      for (int i = 1; i < 4; i++) begin
         if (frameStarts.size() > idx + i)
            checkOutput("wrap_frame_period", frameStarts[idx + i] - frameStarts[idx + i - 1], 42);
      end
      repeat (3) @(negedge clk);

      $display("[TB] zero length");
      dcBefore = doneCount;
      fcBefore = frameCount;
      applyStimulus(9, 0, 1'b1, n);
      checkOutput("zero_done_n1", {31'd0, done}, 32'd1);
      checkOutput("zero_busy_n1", {31'd0, busy}, 32'd0);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
      end
      checkOutput("zero_quiet", bad, 0);
      checkOutput("zero_done_pulses", doneCount - dcBefore, 1);
      checkOutput("zero_no_frames", frameCount - fcBefore, 0);

      $display("[TB] start while busy");
      fcBefore = frameCount;
      applyStimulus(20, 2, 1'b1, n);
      repeat (14) @(negedge clk);
      applyStimulus(100, 5, 1'b0, idx);
      waitDone("busy_start", 300, dc);
      checkOutput("busy_start_done_cycle", dc, n + 3 + 42 + 40);
      repeat (100) @(negedge clk);
      checkOutput("busy_start_frames", frameCount - fcBefore, 2);

      $display("[TB] full depth");
      fcBefore = frameCount;
      dcBefore = doneCount;
      applyStimulus(0, DEPTH, 1'b1, n);
      waitDone("full", 25000, dc);
      checkOutput("full_done_cycle", dc, n + 3 + (DEPTH - 1) * 42 + 40);
      repeat (20) @(negedge clk);
      checkOutput("full_frames", frameCount - fcBefore, DEPTH);
      checkOutput("full_done_pulses", doneCount - dcBefore, 1);
      checkOutput("full_queue_empty", expQ.size(), 0);

      $display("[TB] reset mid-frame");
      fcBefore = frameCount;
      applyStimulus(3, 3, 1'b1, n);
      for (int i = 0; i < 50 && frameCount == fcBefore; i++) @(negedge clk);
      checkOutput("midreset_frame_started", frameCount - fcBefore, 1);
      repeat (13) @(negedge clk);
      reset = 1'b1;
      expQ.delete();
      @(negedge clk);
      checkOutput("midreset_tx", {31'd0, tx}, 32'd1);
      checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
      checkOutput("midreset_mem_ra", {23'd0, mem_ra}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      applyStimulus(7, 1, 1'b1, n);
      waitDone("post_reset", 200, dc);
      checkOutput("post_reset_done_cycle", dc, n + 43);
      repeat (5) @(negedge clk);
      checkOutput("final_queue_empty", expQ.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
